// File: rtl/fs_seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// fs_mult_pkg
// Shared definitions for the radix-4 sequential multiplier:
//   state_t     - controller states (IDLE, RUN, DONE)
//   DIGIT_W     - width of one multiplier digit consumed per RUN cycle
//   fs_latency  - number of RUN cycles for a given operand width
// Optional feature macro (used by the files that import this package):
//   FS_MULT_SIGNED_EN - two's complement operands and product
// -----------------------------------------------------------------------------
package fs_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;

    // One digit of b is retired per RUN cycle, so RUN lasts width/2 cycles.
    function automatic int fs_latency(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/fs_seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// fs_seq_multiplier_if
// Groups the operand and result handshakes of fs_seq_multiplier.
//   start_valid / start_ready / a / b : operand request channel
//   res_valid / res_ready / product   : result channel
//   busy                              : multiplier is in RUN or DONE
// Modports: master (operand producer / result consumer), slave (multiplier).
// -----------------------------------------------------------------------------
interface fs_seq_multiplier_if #(
    parameter int WIDTH = 8
) ();

    logic                   start_valid;
    logic                   start_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   res_valid;
    logic                   res_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output start_valid, a, b, res_ready,
        input  start_ready, res_valid, product, busy
    );

    modport slave (
        input  start_valid, a, b, res_ready,
        output start_ready, res_valid, product, busy
    );

endinterface

// File: rtl/fs_seq_multiplier_digit_pp.sv
// -----------------------------------------------------------------------------
// fs_digit_pp
// Combinational Ferrari-Stefanelli 2-bit partial-product cell: pp = digit * a,
// where digit is 0..3. Only shifts and one add are needed, so no multiplier.
// Ports:
//   a     [WIDTH-1:0]    multiplicand (unsigned magnitude)
//   digit [DIGIT_W-1:0]  2-bit digit of the multiplier
//   pp    [WIDTH+1:0]    digit * a, wide enough for 3 * (2^WIDTH - 1)
// -----------------------------------------------------------------------------
module fs_digit_pp
    import fs_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [DIGIT_W-1:0] digit,
    output logic [WIDTH+1:0]   pp
);

    logic [WIDTH+1:0] a_x1;
    logic [WIDTH+1:0] a_x2;

    assign a_x1 = {2'b00, a};
    assign a_x2 = {1'b0, a, 1'b0};

    always_comb begin
        pp = '0;
        case (digit)
            2'd0:    pp = '0;
            2'd1:    pp = a_x1;
            2'd2:    pp = a_x2;
            2'd3:    pp = a_x2 + a_x1;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/fs_seq_multiplier.sv
// -----------------------------------------------------------------------------
// fs_seq_multiplier
// Sequential radix-4 multiplier. An accepted operand pair is multiplied by
// retiring one 2-bit digit of b per clock (LSB digit first), accumulating
// digit*a at weight 4^k into a 2*WIDTH accumulator. The result is presented
// in DONE until the consumer takes it; latency never depends on the data.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - fs_seq_multiplier_if.slave (start_valid/start_ready/a/b,
//            res_valid/res_ready/product, busy)
// Parameter:
//   WIDTH  - operand width, even and >= 4
// Optional feature macro:
//   FS_MULT_SIGNED_EN - two's complement a, b, product. Magnitudes are taken
//                       at accept and the product is negated when entering
//                       DONE. Without it no sign logic exists at all.
// -----------------------------------------------------------------------------
module fs_seq_multiplier
    import fs_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fs_seq_multiplier_if.slave   bus
);

    localparam int LAT   = fs_latency(WIDTH);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int PW    = 2 * WIDTH;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      product_reg;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH+1:0]   pp;
    logic [CNT_W:0]     shamt;
    logic [PW-1:0]      acc_next;
    logic [PW-1:0]      result;
    logic               accept;

    assign accept = bus.start_valid && (state == IDLE);

`ifdef FS_MULT_SIGNED_EN
    logic sign_reg;

    // The datapath is unsigned; signs are stripped here and re-applied once
    // on the last RUN cycle, so -2^(WIDTH-1) maps to the magnitude 2^(WIDTH-1).
    always_comb begin
        a_mag  = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag  = bus.b[WIDTH-1] ? -bus.b : bus.b;
        result = sign_reg ? -acc_next : acc_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg <= 1'b0;
        end else if (accept) begin
            sign_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    assign a_mag  = bus.a;
    assign b_mag  = bus.b;
    assign result = acc_next;
`endif

    fs_digit_pp #(
        .WIDTH (WIDTH)
    ) u_digit_pp (
        .a     (a_reg),
        .digit (b_reg[DIGIT_W-1:0]),
        .pp    (pp)
    );

    // b_reg is shifted down each cycle, so its low digit is always digit k;
    // k is recovered from the down-counter to place the partial product.
    assign shamt    = {CNT_W'(LAT - 1) - cnt, 1'b0};
    assign acc_next = acc + ({{(WIDTH-2){1'b0}}, pp} << shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_valid) state_next = RUN;
            RUN:     if (cnt == '0)       state_next = DONE;
            DONE:    if (bus.res_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            product_reg <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a_mag;
                        b_reg <= b_mag;
                        acc   <= '0;
                        cnt   <= CNT_W'(LAT - 1);
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    b_reg <= b_reg >> DIGIT_W;
                    if (cnt == '0) begin
                        product_reg <= result;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign bus.busy        = (state == RUN) || (state == DONE);
    assign bus.product     = product_reg;

endmodule

// File: tb/tb_fs_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_fs_seq_multiplier
// Self-checking bench for fs_seq_multiplier. A WIDTH=8 instance is driven with
// directed and random operand pairs; expected products come from plain
// integer arithmetic and are queued at accept, and a monitor compares them
// when res_valid appears. A WIDTH=16 instance covers the wide-operand case.
// Honours FS_MULT_SIGNED_EN for the reference arithmetic.
// -----------------------------------------------------------------------------
module tb_fs_seq_multiplier;

    typedef struct {
        logic [15:0] prod;
        int          acc_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    bit   rand_ready;

    exp_t exp_q[$];

    fs_seq_multiplier_if #(.WIDTH(8))  bus ();
    fs_seq_multiplier_if #(.WIDTH(16)) bus16 ();

    fs_seq_multiplier #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fs_seq_multiplier #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] model8(input logic [7:0] av, input logic [7:0] bv);
`ifdef FS_MULT_SIGNED_EN
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = {{8{av[7]}}, av};
        sb = {{8{bv[7]}}, bv};
        return 16'(sa * sb);
`else
        return {8'd0, av} * {8'd0, bv};
`endif
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] av, input logic [15:0] bv);
`ifdef FS_MULT_SIGNED_EN
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = {{16{av[15]}}, av};
        sb = {{16{bv[15]}}, bv};
        return 32'(sa * sb);
`else
        return {16'd0, av} * {16'd0, bv};
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Issue one operand pair on the 8-bit instance and queue its expected product.
    // After accept, the operand bus carries junk with start_valid pulsed so that
    // anything sampled during RUN would corrupt the result.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expv);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.start_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checkOutput("start_ready_timeout", 64'd0, 64'd1);
            return;
        end
        bus.a           = av;
        bus.b           = bv;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        e.prod    = expv;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic waitDrained();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.start_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) checkOutput("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] expv);
        int n;
        int acc_cyc;
        n = 0;
        @(negedge clk);
        while (!bus16.start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus16.a           = av;
        bus16.b           = bv;
        bus16.start_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc           = cyc;
        bus16.start_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus16.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checkOutput("w16_valid_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("w16_product", 64'(bus16.product), 64'(expv));
            checkOutput("w16_latency", 64'(cyc - acc_cyc + 1), 64'd9);
        end
    endtask

    // Monitor: pops the scoreboard on every new result, and checks that a
    // stalled result holds still and that handshakes complete cleanly.
    logic        prev_valid;
    logic        prev_hs;
    logic [15:0] prev_product;
    exp_t        got;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid   = 1'b0;
            prev_hs      = 1'b0;
            prev_product = '0;
        end else begin
            if (prev_hs) begin
                checkOutput("valid_one_cycle", 64'(bus.res_valid), 64'd0);
                checkOutput("ready_after_hs", 64'(bus.start_ready), 64'd1);
            end
            if (bus.res_valid) begin
                checkOutput("ready_low_in_done", 64'(bus.start_ready), 64'd0);
                if (prev_valid && !prev_hs) begin
                    checkOutput("hold_product", 64'(bus.product), 64'(prev_product));
                end else if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 64'(bus.product), 64'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    checkOutput("product", 64'(bus.product), 64'(got.prod));
                    checkOutput("latency", 64'(cyc - got.acc_cyc + 1), 64'd5);
                end
            end
            prev_valid   = bus.res_valid;
            prev_hs      = bus.res_valid && bus.res_ready;
            prev_product = bus.product;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int n;

        checks            = 0;
        errors            = 0;
        rand_ready        = 1'b0;
        rst_n             = 1'b0;
        bus.start_valid   = 1'b0;
        bus.a             = '0;
        bus.b             = '0;
        bus.res_ready     = 1'b1;
        bus16.start_valid = 1'b0;
        bus16.a           = '0;
        bus16.b           = '0;
        bus16.res_ready   = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_product", 64'(bus.product), 64'd0);
        checkOutput("reset_res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(bus.start_ready), 64'd1);

        // Directed products
        applyStimulus(8'd13, 8'd11, 16'd143);
        applyStimulus(8'd0,  8'd200, 16'd0);
`ifdef FS_MULT_SIGNED_EN
        applyStimulus(8'hFD, 8'd5,   16'hFFF1);
        applyStimulus(8'h80, 8'h80,  16'd16384);
        applyStimulus(8'd127, 8'h80, 16'hC080);
`else
        applyStimulus(8'd255, 8'd255, 16'd65025);
        applyStimulus(8'd255, 8'd1,   16'd255);
`endif
        waitDrained();

        // Stall in DONE with start_valid pulses on new operands
        bus.res_ready = 1'b0;
        applyStimulus(8'd200, 8'd3, model8(8'd200, 8'd3));
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_reached_done", 64'(bus.res_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = 1'b1;
            bus.a           = 8'($urandom);
            bus.b           = 8'($urandom);
            @(negedge clk);
            checkOutput("stall_busy", 64'(bus.busy), 64'd1);
        end
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        applyStimulus(8'd77, 8'd9, model8(8'd77, 8'd9));
        waitDrained();

        // Reset in the second RUN cycle aborts the operation
        applyStimulus(8'd5, 8'd9, 16'd45);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_product", 64'(bus.product), 64'd0);
        checkOutput("abort_res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_abort", 64'(bus.start_ready), 64'd1);
        applyStimulus(8'd3, 8'd7, 16'd21);
        waitDrained();

        // Random operands with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, model8(ra, rb));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.res_ready = 1'b1;
        waitDrained();
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        // Wide instance
`ifdef FS_MULT_SIGNED_EN
        run16(16'd40000, 16'd50000, model16(16'd40000, 16'd50000));
`else
        run16(16'd40000, 16'd50000, 32'd2000000000);
`endif
        run16(16'd1234, 16'd567, model16(16'd1234, 16'd567));

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
